fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage feeding ID: PC register, instruction-memory request handshake and IF/ID
//   pipeline register. Consumes branch redirect (flush_i, branch_pc_i) produced in ID
//   and stall from hazard detection. Holds one skid entry so stalls never lose a fetch,
//   and discards in-flight fetches made stale by a redirect.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset
//   NOP_INSTR  32'h0000_0013   instruction driven on ifid_instr_o when bubble (addi x0,x0,0)
// PORTS
//   clk_i         in   1   clock, all state updates on rising edge
//   rst_i         in   1   synchronous, active-high reset
//   start_i       in   1   begin fetching (honoured in IDLE only)
//   stall_i       in   1   hold IF/ID contents (load-use hazard)
//   flush_i       in   1   branch taken in ID: kill IF/ID, redirect PC
//   branch_pc_i   in   32  redirect target, valid when flush_i=1
//   imem_req_o    out  1   fetch request
//   imem_addr_o   out  32  fetch address (=pc_o), stable while req=1 and ready=0
//   imem_ready_i  in   1   data valid this cycle; completes request
//   imem_data_i   in   32  fetched instruction
//   pc_o          out  32  PC of current/next fetch
//   ifid_valid_o  out  1   IF/ID holds a real instruction
//   ifid_pc_o     out  32  PC of IF/ID instruction
//   ifid_instr_o  out  32  IF/ID instruction
// BEHAVIOUR
//   Reset: state=IDLE, pc=RESET_PC, imem_req_o=0, ifid_valid_o=0, ifid_pc_o=0,
//     ifid_instr_o=NOP_INSTR, skid empty, redirect reg=0. Reset mid-fetch abandons request.
//   States IDLE, FETCH, KILL, HOLD. imem_req_o=1 in FETCH and KILL only.
//   Bubble = ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR, ifid_pc_o unchanged.
//   Priority each cycle: rst_i > flush_i > stall_i. Flush always bubbles IF/ID.
//   IDLE: start_i -> FETCH. flush_i -> pc<=branch_pc_i, stay IDLE.
//   FETCH, ready=1:
//     flush: drop data, pc<=branch_pc_i, stay FETCH.
//     stall: IF/ID holds; skid<=(pc,data); pc<=pc+4; -> HOLD.
//     else: IF/ID<=(valid=1,pc,data); pc<=pc+4; stay FETCH.
//   FETCH, ready=0:
//     flush: redirect<=branch_pc_i; pc unchanged (addr stable); -> KILL.
//     stall: IF/ID holds. else: bubble.
//   KILL: data on ready discarded. ready=1 -> pc<=(flush? branch_pc_i : redirect), -> FETCH.
//     flush with ready=0 overwrites redirect. IF/ID: bubble unless stall (and no flush).
//   HOLD: no request. flush -> skid dropped, pc<=branch_pc_i, -> FETCH.
//     stall -> hold. else IF/ID<=skid (valid=1), -> FETCH.
//   Latency: zero-wait memory (ready same cycle as req) gives 1 instr/cycle; instr at
//     address A appears in IF/ID the cycle after its ready cycle.
//   pc arithmetic modulo 2^32 (0xFFFF_FFFC+4 wraps to 0). No alignment check.
//   start_i outside IDLE ignored; imem_data_i sampled only when ready=1.
// TESTING
//   Reset, start, ready=1 always, RESET_PC=0 -> IF/ID pc 0,4,8 on consecutive cycles, valid=1.
//   Ready after 3 wait cycles -> addr stays 0x0 all 3, IF/ID bubbles, then pc 0 valid.
//   Stall during ready at pc 0x8 for 2 cycles -> req low, IF/ID holds 0x4, then 0x8, then 0xC.
//   Flush(branch_pc=0x40) while 0x10 outstanding -> KILL, 0x10 data dropped, next addr 0x40.
//   flush_i & stall_i same cycle -> ifid_valid_o=0, pc=branch_pc_i.
//   rst_i asserted in HOLD -> next cycle IDLE, req=0, pc=RESET_PC, ifid_valid_o=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request handshake, one-entry skid and IF/ID register.
// Redirects that arrive while a request is outstanding are parked until that request completes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_KILL  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]      state_q,       state_nxt;
    logic [XLEN-1:0] pc_q,          pc_nxt;
    logic            req_q,         req_nxt;
    logic            ifid_valid_q,  ifid_valid_nxt;
    logic [XLEN-1:0] ifid_pc_q,     ifid_pc_nxt;
    logic [XLEN-1:0] ifid_instr_q,  ifid_instr_nxt;
    logic [XLEN-1:0] skid_pc_q,     skid_pc_nxt;
    logic [XLEN-1:0] skid_instr_q,  skid_instr_nxt;
    logic [XLEN-1:0] redirect_q,    redirect_nxt;

    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + XLEN'(4);

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            redirect_q   <= '0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            req_q        <= req_nxt;
            ifid_valid_q <= ifid_valid_nxt;
            ifid_pc_q    <= ifid_pc_nxt;
            ifid_instr_q <= ifid_instr_nxt;
            skid_pc_q    <= skid_pc_nxt;
            skid_instr_q <= skid_instr_nxt;
            redirect_q   <= redirect_nxt;
        end
    end

    // Next-state and next-register values; flush beats stall everywhere
    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        ifid_valid_nxt = ifid_valid_q;
        ifid_pc_nxt    = ifid_pc_q;
        ifid_instr_nxt = ifid_instr_q;
        skid_pc_nxt    = skid_pc_q;
        skid_instr_nxt = skid_instr_q;
        redirect_nxt   = redirect_q;

        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    pc_nxt         = branch_pc_i;
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                end else if (start_i) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready_i) begin
                    if (flush_i) begin
                        pc_nxt         = branch_pc_i;
                        ifid_valid_nxt = 1'b0;
                        ifid_instr_nxt = NOP_INSTR;
                    end else if (stall_i) begin
                        skid_pc_nxt    = pc_q;
                        skid_instr_nxt = imem_data_i;
                        pc_nxt         = pc_inc;
                        state_nxt      = S_HOLD;
                    end else begin
                        ifid_valid_nxt = 1'b1;
                        ifid_pc_nxt    = pc_q;
                        ifid_instr_nxt = imem_data_i;
                        pc_nxt         = pc_inc;
                    end
                end else begin
                    if (flush_i) begin
                        redirect_nxt   = branch_pc_i;
                        ifid_valid_nxt = 1'b0;
                        ifid_instr_nxt = NOP_INSTR;
                        state_nxt      = S_KILL;
                    end else if (!stall_i) begin
                        ifid_valid_nxt = 1'b0;
                        ifid_instr_nxt = NOP_INSTR;
                    end
                end
            end
            S_KILL: begin
                if (flush_i || !stall_i) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                end
                if (imem_ready_i) begin
                    pc_nxt    = flush_i ? branch_pc_i : redirect_q;
                    state_nxt = S_FETCH;
                end else if (flush_i) begin
                    redirect_nxt = branch_pc_i;
                end
            end
            default: begin
                if (flush_i) begin
                    pc_nxt         = branch_pc_i;
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = NOP_INSTR;
                    state_nxt      = S_FETCH;
                end else if (!stall_i) begin
                    ifid_valid_nxt = 1'b1;
                    ifid_pc_nxt    = skid_pc_q;
                    ifid_instr_nxt = skid_instr_q;
                    state_nxt      = S_FETCH;
                end
            end
        endcase

        req_nxt = (state_nxt == S_FETCH) || (state_nxt == S_KILL);
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios then random traffic, all against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] branch_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] pc_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .branch_pc_i  (branch_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_instr_o (ifid_instr_o)
    );

    always #5 clk = ~clk;

    // Reference model: fetch engine described by activity flags rather than states
    logic        m_active;     // start seen since reset
    logic        m_stale;      // outstanding request must be discarded
    logic [31:0] m_target;     // where to go once the stale request completes
    logic        m_parked;     // one fetched instruction waiting for the stall to clear
    logic [31:0] m_park_pc, m_park_ins;
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ipc, m_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_v   = 1'b0;
        m_ins = NOP;
    endtask

    task automatic model_update(input logic rst, input logic start, input logic stall,
                                input logic flush, input logic [31:0] bpc,
                                input logic ready, input logic [31:0] data);
        if (rst) begin
            m_active = 0; m_stale = 0; m_target = 0; m_parked = 0;
            m_pc = 0; m_v = 0; m_ipc = 0; m_ins = NOP;
        end else if (!m_active) begin
            if (flush) begin m_pc = bpc; model_bubble(); end
            else if (start) m_active = 1;
        end else if (m_parked) begin
            if (flush) begin m_parked = 0; m_pc = bpc; model_bubble(); end
            else if (!stall) begin
                m_v = 1; m_ipc = m_park_pc; m_ins = m_park_ins; m_parked = 0;
            end
        end else if (m_stale) begin
            if (flush || !stall) model_bubble();
            if (ready) begin m_pc = flush ? bpc : m_target; m_stale = 0; end
            else if (flush) m_target = bpc;
        end else if (ready) begin
            if (flush) begin m_pc = bpc; model_bubble(); end
            else if (stall) begin
                m_parked = 1; m_park_pc = m_pc; m_park_ins = data; m_pc = m_pc + 32'd4;
            end else begin
                m_v = 1; m_ipc = m_pc; m_ins = data; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (flush) begin m_target = bpc; m_stale = 1; model_bubble(); end
            else if (!stall) model_bubble();
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare all outputs
    task automatic step(input logic rst, input logic start, input logic stall,
                        input logic flush, input logic [31:0] bpc, input logic ready);
        logic [31:0] data;
        logic        exp_req;
        data = ready ? mem_word(m_pc) : $urandom();
        rst_i = rst; start_i = start; stall_i = stall; flush_i = flush;
        branch_pc_i = bpc; imem_ready_i = ready; imem_data_i = data;
        model_update(rst, start, stall, flush, bpc, ready, data);
        @(posedge clk);
        #1;
        exp_req = m_active && !m_parked;
        check32("req",   32'(imem_req_o),   32'(exp_req));
        check32("pc",    pc_o,              m_pc);
        check32("addr",  imem_addr_o,       m_pc);
        check32("valid", 32'(ifid_valid_o), 32'(m_v));
        check32("ifpc",  ifid_pc_o,         m_ipc);
        check32("instr", ifid_instr_o,      m_ins);
    endtask

    initial begin
        logic [31:0] bpc;
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        check32("rst_pc", pc_o, 32'h0);
        check32("rst_req", 32'(imem_req_o), 32'h0);
        check32("rst_instr", ifid_instr_o, NOP);

        // Zero-wait memory: IF/ID pc 0,4,8 on consecutive cycles
        step(0, 1, 0, 0, 0, 0);
        check32("start_req", 32'(imem_req_o), 32'h1);
        step(0, 0, 0, 0, 0, 1);
        check32("zw_pc0", ifid_pc_o, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        check32("zw_pc4", ifid_pc_o, 32'h4);
        step(0, 0, 0, 0, 0, 1);
        check32("zw_pc8", ifid_pc_o, 32'h8);
        check32("zw_valid", 32'(ifid_valid_o), 32'h1);

        // Three wait cycles at address 0
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check32("wait_addr", imem_addr_o, 32'h0);
            check32("wait_bubble", 32'(ifid_valid_o), 32'h0);
        end
        step(0, 0, 0, 0, 0, 1);
        check32("wait_done_pc", ifid_pc_o, 32'h0);
        check32("wait_done_ins", ifid_instr_o, mem_word(32'h0));

        // Stall while 0x8 returns: skid holds it for two cycles
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        check32("stall_req", 32'(imem_req_o), 32'h0);
        check32("stall_hold4", ifid_pc_o, 32'h4);
        step(0, 0, 1, 0, 0, 0);
        check32("stall_hold4b", ifid_pc_o, 32'h4);
        step(0, 0, 0, 0, 0, 0);
        check32("skid_out8", ifid_pc_o, 32'h8);
        step(0, 0, 0, 0, 0, 1);
        check32("after_skid_c", ifid_pc_o, 32'hC);

        // Flush while 0x10 outstanding: data dropped, next address 0x40
        step(0, 0, 0, 1, 32'h40, 0);
        check32("kill_addr", imem_addr_o, 32'h10);
        step(0, 0, 0, 0, 0, 1);
        check32("kill_drop", 32'(ifid_valid_o), 32'h0);
        check32("kill_next", imem_addr_o, 32'h40);

        // Flush and stall together
        step(0, 0, 1, 1, 32'h80, 1);
        check32("fs_valid", 32'(ifid_valid_o), 32'h0);
        check32("fs_pc", pc_o, 32'h80);

        // Reset while holding
        step(0, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        check32("rst_hold_req", 32'(imem_req_o), 32'h0);
        check32("rst_hold_pc", pc_o, 32'h0);
        check32("rst_hold_valid", 32'(ifid_valid_o), 32'h0);

        // PC wraps modulo 2^32
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 0, 1);
        check32("wrap_pc", pc_o, 32'h0);
        check32("wrap_ifpc", ifid_pc_o, 32'hFFFF_FFFC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 255)) << 2);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 11) == 0,
                 bpc,
                 $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
